// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and CTRL layout for the machine timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;
    localparam logic [4:0] STATUS_OFF      = 5'h14;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef struct packed {
        logic ie;
        logic en;
    } timer_ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
        return {30'b0, c};
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// Latency: tick is combinational from the current count and en.
// Backpressure: none; the count holds while en=0 and clr forces it back to 0.
module timer_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE + 1);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer (mtime/mtimecmp) driving a level timer_interrupt.
// Latency: loads are combinational; stores commit at the edge; interrupt lags a register change by 1 cycle.
// Backpressure: none; every access completes in the cycle it is presented.
module mtimer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        timer_interrupt
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    timer_ctrl_t ctrl;
    logic [4:0]  off;
    logic        wr_hit;
    logic        tick;
    logic        tick_clr;
    logic        match;
    logic        unused_addr_lsb;

    // Byte lanes are ignored: every access is treated as a full word.
    assign off             = {addr[4:2], 2'b00};
    assign unused_addr_lsb = &{1'b0, addr[1:0]};
    assign sel             = (addr[31:5] == BASE_ADDR[31:5]);
    assign wr_hit          = wr_en && sel;
    assign match           = (mtime >= mtimecmp);
    assign tick_clr        = wr_hit && (off == CTRL_OFF) && !wdata[CTRL_EN];

    timer_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (ctrl.en),
        .clr (tick_clr),
        .tick(tick)
    );

    // A software write to either mtime half swallows a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr_hit && (off == MTIME_LO_OFF)) begin
            mtime[31:0] <= wdata;
        end else if (wr_hit && (off == MTIME_HI_OFF)) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtimecmp <= '1;
            ctrl     <= '0;
        end else if (wr_hit) begin
            case (off)
                MTIMECMP_LO_OFF: mtimecmp[31:0]  <= wdata;
                MTIMECMP_HI_OFF: mtimecmp[63:32] <= wdata;
                CTRL_OFF: begin
                    ctrl.ie <= wdata[CTRL_IE];
                    ctrl.en <= wdata[CTRL_EN];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= ctrl.ie && match;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && rd_en) begin
            case (off)
                MTIME_LO_OFF:    rdata = mtime[31:0];
                MTIME_HI_OFF:    rdata = mtime[63:32];
                MTIMECMP_LO_OFF: rdata = mtimecmp[31:0];
                MTIMECMP_HI_OFF: rdata = mtimecmp[63:32];
                CTRL_OFF:        rdata = ctrl_to_word(ctrl);
                STATUS_OFF:      rdata = {31'b0, match};
                default:         rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: two instances (PRESCALE=1 and PRESCALE=4) share one bus.
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        sel1, sel4, irq1, irq4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #50 clk = ~clk;

    mtimer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata1), .sel(sel1), .timer_interrupt(irq1)
    );

    mtimer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata4), .sel(sel4), .timer_interrupt(irq4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the store commits at the following posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = '0;
    endtask

    task automatic rd(input bit four, input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        chk(tag_q.pop_front(), four ? rdata4 : rdata1, exp_q.pop_front());
        rd_en = 1'b0;
        addr  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and register defaults
        cyc(3);
        rst = 1'b1;
        rd(0, BASE + 32'h00, 32'h0, "rst_mtime_lo");
        rd(0, BASE + 32'h04, 32'h0, "rst_mtime_hi");
        rd(0, BASE + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(0, BASE + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(0, BASE + 32'h10, 32'h0, "rst_ctrl");
        rd(0, BASE + 32'h14, 32'h0, "rst_status");
        rd(0, BASE + 32'h18, 32'h0, "rst_reserved");
        chk("rst_irq1", irq1, 0);
        chk("rst_irq4", irq4, 0);
        addr = BASE + 32'h1C; #1 chk("sel_top_word", sel1, 1);
        addr = BASE + 32'h20; #1 chk("sel_past_end", sel4, 0);
        addr = BASE + 32'h08; rd_en = 1'b0; #1 chk("rdata_no_rd_en", rdata1, 0);
        addr = '0;

        // prescaler: 40 enabled cycles
        wr(BASE + 32'h10, 32'h1);
        cyc(40);
        rd(1, BASE, 32'd10, "ps4_count");
        rd(0, BASE, 32'd40, "ps1_count");
        wr(BASE + 32'h10, 32'h0);
        cyc(10);
        rd(1, BASE, 32'd10, "ps4_frozen");
        rd(0, BASE, 32'd41, "ps1_frozen");

        // 32-bit carry into MTIME_HI
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'h0);
        wr(BASE + 32'h10, 32'h1);
        cyc(1);
        rd(0, BASE + 32'h04, 32'h1, "ps1_carry_hi");
        rd(0, BASE + 32'h00, 32'h0, "ps1_carry_lo");
        rd(1, BASE + 32'h00, 32'hFFFF_FFFF, "ps4_pre_tick");
        cyc(3);
        rd(1, BASE + 32'h04, 32'h1, "ps4_carry_hi");
        rd(1, BASE + 32'h00, 32'h0, "ps4_carry_lo");
        wr(BASE + 32'h10, 32'h0);

        // compare and interrupt
        wr(BASE + 32'h04, 32'h0);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h08, 32'd100);
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h10, 32'h3);
        cyc(100);
        rd(0, BASE + 32'h00, 32'd100, "mtime_at_cmp");
        rd(0, BASE + 32'h14, 32'h1, "status_match");
        chk("irq_latency", irq1, 0);
        cyc(1);
        chk("irq_rise", irq1, 1);
        cyc(5);
        chk("irq_hold", irq1, 1);
        wr(BASE + 32'h08, 32'd1000);
        chk("irq_at_cmp_wr", irq1, 1);
        cyc(1);
        chk("irq_drop", irq1, 0);

        // write vs tick, read-before-write
        wr(BASE + 32'h00, 32'd5);
        rd(0, BASE + 32'h00, 32'd5, "wr_beats_tick");
        rd(0, BASE + 32'h04, 32'h0, "wr_lo_hi_hold");
        wdata = 32'd2000;
        wr_en = 1'b1;
        rd(0, BASE + 32'h08, 32'd1000, "rd_wr_prewrite");
        addr  = BASE + 32'h08;
        @(negedge clk);
        wr_en = 1'b0;
        rd(0, BASE + 32'h08, 32'd2000, "rd_after_wr");
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        rd(0, BASE + 32'h00, 32'hFFFF_FFFF, "wr_lo_max");
        cyc(1);
        rd(0, BASE + 32'h04, 32'h1, "carry_after_wr_hi");
        rd(0, BASE + 32'h00, 32'h0, "carry_after_wr_lo");

        // reset mid-count with interrupt high
        cyc(2);
        chk("irq_pre_rst", irq1, 1);
        rst   = 1'b0;
        addr  = BASE;
        wdata = 32'd123;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("rst_clears_irq1", irq1, 0);
        chk("rst_clears_irq4", irq4, 0);
        rd(0, BASE + 32'h00, 32'h0, "rst2_mtime_lo");
        rd(0, BASE + 32'h04, 32'h0, "rst2_mtime_hi");
        rd(0, BASE + 32'h10, 32'h0, "rst2_ctrl");
        rd(0, BASE + 32'h0C, 32'hFFFF_FFFF, "rst2_cmp_hi");
        rst = 1'b1;
        cyc(1);
        addr = BASE + 32'h40; #1 chk("sel_unmapped", sel1, 0);
        wr(BASE + 32'h40, 32'd55);
        wr(BASE + 32'h18, 32'd7);
        rd(0, BASE + 32'h00, 32'h0, "unmapped_wr_ignored");
        rd(0, BASE + 32'h18, 32'h0, "reserved_wr_ignored");
        rd(1, BASE + 32'h10, 32'h0, "ctrl_after_unmapped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
